telemetry_unpacker: RTL and testbench

//  Receiving end of the 128-bit telemetry stream that the register map sends as two 64-bit words.
//  - H word: {4'b0001, error_code[7:0], mpu_data_pack[111:60]}
//  - L word: {4'b0010, mpu_data_pack[59:0]}

---
 rtl/telemetry_unpacker.sv | 169 ++++++++++++++++
 tb/tb_telemetry_unpacker.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/telemetry_unpacker.sv
// Rebuilds {error_code, mpu_data_pack} frames from tagged H/L 64-bit telemetry words,
// with a valid/ready frame handshake and saturating tag-error / timeout counters.
module telemetry_unpacker #(
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter logic [3:0]  TAG_H       = 4'b0001,
  parameter logic [3:0]  TAG_L       = 4'b0010
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [63:0]  word_in,
  input  logic         word_valid,
  output logic         word_ready,
  output logic         frame_valid,
  input  logic         frame_ready,
  output logic [7:0]   error_code,
  output logic [111:0] mpu_data_pack,
  output logic [7:0]   tag_err_cnt,
  output logic [7:0]   timeout_cnt,
  input  logic         cnt_clr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_L = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state_r;
  state_t      next_state_s;
  logic [15:0] timer_r;
  logic [7:0]  err_r;
  logic [51:0] hi_r;

  logic        accept_s;
  logic [3:0]  tag_s;
  logic        latch_h_s;
  logic        load_frame_s;
  logic        frame_clr_s;
  logic        timer_clr_s;
  logic        timer_inc_s;
  logic        tag_err_s;
  logic        timeout_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == 8'hFF) begin
      return 8'hFF;
    end else begin
      return v + 8'd1;
    end
  endfunction

  assign word_ready = (state_r != HOLD);
  assign accept_s   = word_valid & word_ready;
  assign tag_s      = word_in[63:60];

  // Next-state and event decode; an accepted word always wins over a timeout.
  always_comb begin
    next_state_s = state_r;
    latch_h_s    = 1'b0;
    load_frame_s = 1'b0;
    frame_clr_s  = 1'b0;
    timer_clr_s  = 1'b0;
    timer_inc_s  = 1'b0;
    tag_err_s    = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (tag_s == TAG_H) begin
            latch_h_s    = 1'b1;
            timer_clr_s  = 1'b1;
            next_state_s = WAIT_L;
          end else begin
            tag_err_s    = 1'b1;
            next_state_s = IDLE;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT_L: begin
        if (accept_s) begin
          if (tag_s == TAG_L) begin
            load_frame_s = 1'b1;
            next_state_s = HOLD;
          end else if (tag_s == TAG_H) begin
            // A fresh H word resynchronises onto the newest half-frame.
            latch_h_s    = 1'b1;
            timer_clr_s  = 1'b1;
            tag_err_s    = 1'b1;
            next_state_s = WAIT_L;
          end else begin
            tag_err_s    = 1'b1;
            next_state_s = IDLE;
          end
        end else if (timer_r == TIMER_LAST) begin
          timeout_s    = 1'b1;
          next_state_s = IDLE;
        end else begin
          timer_inc_s  = 1'b1;
          next_state_s = WAIT_L;
        end
      end
      HOLD: begin
        if (frame_ready) begin
          frame_clr_s  = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = HOLD;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, H latch, WAIT_L timer and frame output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      timer_r       <= 16'd0;
      err_r         <= 8'd0;
      hi_r          <= 52'd0;
      frame_valid   <= 1'b0;
      error_code    <= 8'd0;
      mpu_data_pack <= 112'd0;
    end else begin
      state_r <= next_state_s;
      if (timer_clr_s) begin
        timer_r <= 16'd0;
      end else if (timer_inc_s) begin
        timer_r <= timer_r + 16'd1;
      end
      if (latch_h_s) begin
        err_r <= word_in[59:52];
        hi_r  <= word_in[51:0];
      end
      if (load_frame_s) begin
        frame_valid   <= 1'b1;
        error_code    <= err_r;
        mpu_data_pack <= {hi_r, word_in[59:0]};
      end else if (frame_clr_s) begin
        frame_valid   <= 1'b0;
      end
    end
  end

  // Saturating event counters; a clear drops any same-cycle event.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_err_cnt <= 8'd0;
      timeout_cnt <= 8'd0;
    end else if (cnt_clr) begin
      tag_err_cnt <= 8'd0;
      timeout_cnt <= 8'd0;
    end else begin
      if (tag_err_s) begin
        tag_err_cnt <= sat_inc(tag_err_cnt);
      end
      if (timeout_s) begin
        timeout_cnt <= sat_inc(timeout_cnt);
      end
    end
  end

endmodule

// File: tb/tb_telemetry_unpacker.sv
// Directed bench for telemetry_unpacker: expected frames go into a scoreboard queue and a
// monitor pops/compares on every frame handshake; counters and handshake signals are spot-checked.
module tb_telemetry_unpacker;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  word_in;
  logic         word_valid;
  logic         word_ready;
  logic         frame_valid;
  logic         frame_ready;
  logic [7:0]   error_code;
  logic [111:0] mpu_data_pack;
  logic [7:0]   tag_err_cnt;
  logic [7:0]   timeout_cnt;
  logic         cnt_clr;

  int n_cmp = 0;
  int n_bad = 0;
  logic [119:0] exp_q[$];

  telemetry_unpacker #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .error_code(error_code), .mpu_data_pack(mpu_data_pack),
    .tag_err_cnt(tag_err_cnt), .timeout_cnt(timeout_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one word and hold it until the DUT accepts it (bounded).
  task automatic send(input logic [63:0] w);
    int n;
    n = 0;
    word_in    = w;
    word_valid = 1'b1;
    @(negedge clk);
    while (!word_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (!word_ready) begin
      n_bad++;
      $display("FAIL send_wait: word_ready stuck at 0 for word %0h", w);
    end
    @(posedge clk);
    #1;
    word_valid = 1'b0;
  endtask

  function automatic logic [63:0] mk_h(input logic [7:0] e, input logic [51:0] hi);
    return {4'h1, e, hi};
  endfunction

  function automatic logic [63:0] mk_l(input logic [59:0] lo);
    return {4'h2, lo};
  endfunction

  // Scoreboard monitor: every frame handshake must match the oldest expected frame.
  initial begin
    logic [119:0] e;
    forever begin
      @(negedge clk);
      if (frame_valid && frame_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame: got %0h expected none", {error_code, mpu_data_pack});
        end else begin
          e = exp_q.pop_front();
          check("frame", {8'd0, error_code, mpu_data_pack}, {8'd0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [119:0] f5;
    rst = 1'b1; word_in = 64'd0; word_valid = 1'b0; frame_ready = 1'b1; cnt_clr = 1'b0;
    step(3);
    rst = 1'b0;
    check("rst_frame_valid", 128'(frame_valid), 128'd0);
    check("rst_outputs", {8'd0, error_code, mpu_data_pack}, 128'd0);
    check("rst_counters", {tag_err_cnt, timeout_cnt}, 128'd0);
    check("rst_word_ready", 128'(word_ready), 128'd1);

    // 1: basic frame, latency 1
    exp_q.push_back({8'hA5, 52'h1_2345_6789_ABCD, 60'hFED_CBA9_8765_4321});
    send(mk_h(8'hA5, 52'h1_2345_6789_ABCD));
    send(mk_l(60'hFED_CBA9_8765_4321));
    check("t1_frame_valid", 128'(frame_valid), 128'd1);
    check("t1_error_code", 128'(error_code), 128'hA5);
    step(2);
    check("t1_keep_after_accept", 128'(mpu_data_pack),
          128'({52'h1_2345_6789_ABCD, 60'hFED_CBA9_8765_4321}));

    // 2: bad tags in IDLE
    send(mk_l(60'h123));
    send({4'h7, 60'h0});
    check("t2_tag_err", 128'(tag_err_cnt), 128'd2);
    check("t2_no_frame", 128'(frame_valid), 128'd0);
    cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;
    check("t2_clr", 128'(tag_err_cnt), 128'd0);

    // 3: timeout after exactly 8 idle cycles in WAIT_L
    send(mk_h(8'h33, 52'h5));
    step(7);
    check("t3_no_timeout_yet", 128'(timeout_cnt), 128'd0);
    step(1);
    check("t3_timeout", 128'(timeout_cnt), 128'd1);
    send(mk_l(60'h9));
    check("t3_l_in_idle", 128'(tag_err_cnt), 128'd1);
    check("t3_no_frame", 128'(frame_valid), 128'd0);
    cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;

    // 4: resync on a second H word
    exp_q.push_back({8'h22, 52'hB_BBBB_BBBB_BBBB, 60'h0AA_5555_0000_FFFF});
    send(mk_h(8'h11, 52'hA_AAAA_AAAA_AAAA));
    send(mk_h(8'h22, 52'hB_BBBB_BBBB_BBBB));
    send(mk_l(60'h0AA_5555_0000_FFFF));
    check("t4_tag_err", 128'(tag_err_cnt), 128'd1);
    step(1);
    cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;

    // 5: back-pressure for 10 cycles with word_valid high
    f5 = {8'h5C, 52'hC_0FFE_E000_1234, 60'h876_5432_1FED_CBA9};
    exp_q.push_back(f5);
    frame_ready = 1'b0;
    send(mk_h(8'h5C, 52'hC_0FFE_E000_1234));
    send(mk_l(60'h876_5432_1FED_CBA9));
    word_in = mk_h(8'h77, 52'h7); word_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_word_ready_low", 128'(word_ready), 128'd0);
      check("t5_hold_stable", {8'd0, frame_valid ? {error_code, mpu_data_pack} : 120'd0}, {8'd0, f5});
      @(posedge clk); #1;
    end
    word_valid = 1'b0; frame_ready = 1'b1;
    step(1);
    check("t5_released", {frame_valid, word_ready}, 128'b01);
    check("t5_kept_output", 128'(error_code), 128'h5C);
    exp_q.push_back({8'h66, 52'h6, 60'h66});
    send(mk_h(8'h66, 52'h6));
    send(mk_l(60'h66));
    step(2);
    check("t5_no_tag_err", 128'(tag_err_cnt), 128'd0);

    // 6: saturation and clear on the 300th bad tag
    word_in = {4'hF, 60'h0}; word_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cnt_clr = (i == 299);
      step(1);
      if (i == 253) check("t6_cnt_254", 128'(tag_err_cnt), 128'd254);
      if (i == 254) check("t6_cnt_255", 128'(tag_err_cnt), 128'd255);
      if (i == 298) check("t6_saturated", 128'(tag_err_cnt), 128'd255);
    end
    cnt_clr = 1'b0; word_valid = 1'b0;
    check("t6_cleared", 128'(tag_err_cnt), 128'd0);

    // 6b: reset mid-frame drops the half-frame
    send(mk_h(8'h99, 52'h9));
    rst = 1'b1; step(1); rst = 1'b0;
    check("t6_rst_outputs", {8'd0, error_code, mpu_data_pack}, 128'd0);
    send(mk_l(60'h99));
    step(2);
    check("t6_rst_tag_err", 128'(tag_err_cnt), 128'd1);
    check("t6_rst_no_frame", 128'(frame_valid), 128'd0);
    check("sb_drained", 128'(exp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
